// File: rtl/apb_slave_regfile.sv
// APB completer fronting a word-addressed register file.
// The number of wait states is programmable, and every bus output is registered.
module apb_slave_regfile #(
  parameter int          DEPTH       = 128,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS_M1   = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic [31:0]      r_wdata;
  logic [31:0]      r_prdata;
  logic             r_pready;
  logic             r_pslverr;
  logic [31:0]      r_mem [DEPTH];

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_pready_nxt;
  logic             w_pslverr_nxt;
  logic             w_latch;
  logic             w_load;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_load_err;
  logic             w_load_wr;
  logic             w_commit;

  // Decode of the live bus address, used only when a setup phase is sampled.
  assign w_off = PADDR - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];
  assign w_err = (w_off[1:0] != 2'b00) | (PADDR < BASE_ADDR) |
                 ({2'b00, w_off[31:2]} >= DEPTH_W);

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pready_nxt  = r_pready;
    w_pslverr_nxt = r_pslverr;
    w_latch       = 1'b0;
    w_load        = 1'b0;
    w_load_idx    = r_idx;
    w_load_err    = r_err;
    w_load_wr     = r_write;
    w_commit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_latch = 1'b1;
          if (WAIT_STATES == 0) begin
            // With no wait states, the response is prepared straight from the setup sample.
            w_state_nxt   = S_READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err;
            w_load        = 1'b1;
            w_load_idx    = w_idx;
            w_load_err    = w_err;
            w_load_wr     = PWRITE;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_M1;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else if (PENABLE) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt   = S_READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = r_err;
            w_load        = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      S_READY: begin
        if (!PSEL) begin
          w_state_nxt   = S_IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else if (PENABLE) begin
          w_commit      = r_write & ~r_err;
          w_state_nxt   = S_IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      if (w_latch) begin
        r_write <= PWRITE;
        r_idx   <= w_idx;
        r_err   <= w_err;
        r_wdata <= PWDATA;
      end
      // PRDATA only changes on a read response; it holds across writes and aborts.
      if (w_load && !w_load_wr) begin
        r_prdata <= w_load_err ? 32'h0 : r_mem[w_load_idx];
      end
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile.
// Instance 0 has no wait states and instance 1 has three; both share one bus.
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  psel = 2'b00;
  logic        pen = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] model [128];

  always #5 clk = ~clk;

  apb_slave_regfile #(.DEPTH(128), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .PCLK(clk), .PRESET(rst_n), .PSEL(psel[0]), .PENABLE(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.DEPTH(128), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut1 (
    .PCLK(clk), .PRESET(rst_n), .PSEL(psel[1]), .PENABLE(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]));

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer. During the access phase, address and data are scrambled
  // so that the slave has to rely on its setup-phase sample.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int nlow);
    @(negedge clk);
    psel    = 2'b00;
    psel[d] = 1'b1;
    pen     = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(negedge clk);
    pen    = 1'b1;
    paddr  = addr ^ 32'h4;
    pwdata = ~wd;
    nlow   = 0;
    while (pready[d] !== 1'b1 && nlow < 32) begin
      @(negedge clk);
      nlow++;
    end
    rd = prdata[d];
    er = pslverr[d];
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 2'b00;
    pen  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          nlow;
    logic        seen;

    for (int i = 0; i < 128; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_vec("rst_prdata0", prdata[0], 32'h0);
    chk_vec("rst_pready0", {31'h0, pready[0]}, 32'h0);
    chk_vec("rst_pslverr0", {31'h0, pslverr[0]}, 32'h0);
    chk_vec("rst_pready1", {31'h0, pready[1]}, 32'h0);
    rst_n = 1'b1;

    // Read of register 0 with no wait states
    xfer(0, 1'b0, 32'h0, 32'h0, rd, er, nlow);
    chk_vec("rd0_lat", nlow, 0);
    chk_vec("rd0_data", rd, 32'h0);
    chk_vec("rd0_err", {31'h0, er}, 32'h0);

    // Write followed by a back-to-back read of the same register
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, nlow);
    model[4] = 32'hDEADBEEF;
    chk_vec("wr10_lat", nlow, 0);
    chk_vec("wr10_err", {31'h0, er}, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, nlow);
    chk_vec("rd10_lat", nlow, 0);
    chk_vec("rd10_data", rd, 32'hDEADBEEF);
    chk_vec("rd10_err", {31'h0, er}, 32'h0);

    // A write must leave PRDATA holding the previous read value
    xfer(0, 1'b1, 32'h14, 32'h11111111, rd, er, nlow);
    model[5] = 32'h11111111;
    chk_vec("wr14_prdata_hold", rd, 32'hDEADBEEF);

    // Three wait states: write and read back the last register
    xfer(1, 1'b1, 32'h1FC, 32'h12345678, rd, er, nlow);
    chk_vec("ws3_wr_lat", nlow, 3);
    chk_vec("ws3_wr_err", {31'h0, er}, 32'h0);
    xfer(1, 1'b0, 32'h1FC, 32'h0, rd, er, nlow);
    chk_vec("ws3_rd_lat", nlow, 3);
    chk_vec("ws3_rd_data", rd, 32'h12345678);
    bus_idle();

    // Out-of-range write: error for a single cycle, and no register changes
    xfer(0, 1'b1, 32'h200, 32'hFFFFFFFF, rd, er, nlow);
    chk_vec("wr200_err", {31'h0, er}, 32'h1);
    bus_idle();
    chk_vec("wr200_err_drop", {31'h0, pslverr[0]}, 32'h0);
    chk_vec("wr200_rdy_drop", {31'h0, pready[0]}, 32'h0);
    for (int i = 0; i < 128; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, rd, er, nlow);
      chk_vec($sformatf("sweep_%0d", i), rd, model[i]);
    end

    // Misaligned read
    xfer(0, 1'b0, 32'h3, 32'h0, rd, er, nlow);
    chk_vec("rd3_err", {31'h0, er}, 32'h1);
    chk_vec("rd3_data", rd, 32'h0);
    bus_idle();

    // Abort in the second wait cycle: PREADY never rises and the write is dropped
    seen = 1'b0;
    @(negedge clk);
    psel = 2'b10; pen = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hA5A5A5A5;
    @(negedge clk);
    pen = 1'b1;
    seen |= pready[1];
    @(negedge clk);
    seen |= pready[1];
    psel = 2'b00; pen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= pready[1];
    end
    chk_vec("abort_no_ready", {31'h0, seen}, 32'h0);
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er, nlow);
    chk_vec("abort_rd_lat", nlow, 3);
    chk_vec("abort_rd_data", rd, 32'h0);

    // Asynchronous reset in the middle of a wait
    xfer(1, 1'b1, 32'h4, 32'h55, rd, er, nlow);
    xfer(1, 1'b0, 32'h4, 32'h0, rd, er, nlow);
    chk_vec("pre_rst_rd4", rd, 32'h55);
    @(negedge clk);
    psel = 2'b10; pen = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h77;
    @(negedge clk);
    pen = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_vec("arst_prdata1", prdata[1], 32'h0);
    chk_vec("arst_pready1", {31'h0, pready[1]}, 32'h0);
    chk_vec("arst_pslverr1", {31'h0, pslverr[1]}, 32'h0);
    @(negedge clk);
    psel = 2'b00; pen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h4, 32'h0, rd, er, nlow);
    chk_vec("post_rst_rd4", rd, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, nlow);
    chk_vec("post_rst_rd10", rd, 32'h0);
    bus_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
